instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Fetch-side front end of the 3-stage RISC-V core. It owns the fetch PC and issues requests to the synchronous instruction memory, which has a fixed 1-cycle read latency. It buffers returned instructions with their PCs in a small queue and hands them to the decode stage through a valid/ready handshake. Redirects from the datapath (taken branch or jump) flush the queue and drop stale responses. With this block in place, decode stalls never lose an instruction read from BRAM.

## Interface
- `XLEN`, 32, data/address width.
- `DEPTH`, 4, queue entries; power of two, ≥2.
- `RESET_PC`, 32'h4000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `redirect_valid`  in  1  taken branch/jump from the datapath this cycle.
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- `imem_req`  out  1  read enable to instruction memory.
- `imem_addr`  out  XLEN  word-aligned read address.
- `imem_rdata`  in  XLEN  read data; valid the cycle after an `imem_req` cycle.
- `instr_valid`  out  1  `instr_out`/`instr_pc` hold a valid instruction.
- `instr_ready`  in  1  decode accepts; a pop happens when `instr_valid` and `instr_ready` are both high.
- `instr_out`  out  XLEN  instruction to decode.
- `instr_pc`  out  XLEN  PC of `instr_out`.

## Operation
- State:
  - `fetch_pc`: next sequential address.
  - `inflight`: 1 if `imem_req` was asserted in the previous cycle.
  - `inflight_pc`.
  - Circular queue of {pc, instr}, with head, tail and count.
- Issue rule:
  - Normal cycle: `imem_req` = (count + `inflight` < `DEPTH`).
  - Redirect cycle: `imem_req` = 1 unconditionally.
- Address: `imem_addr` = `redirect_valid` ? {`redirect_pc`[XLEN-1:2], 2'b00} : `fetch_pc`.
- On issue, `fetch_pc` ← `imem_addr` + 4.
- Response: when `inflight` is 1, {`inflight_pc`, `imem_rdata`} is pushed, unless `redirect_valid` is high that cycle, in which case the response is discarded.
- Redirect cycle:
  - count, head and tail reset to 0.
  - `instr_valid` is 0.
  - `instr_ready` is ignored.
- Output: the head entry; `instr_valid` = (count ≠ 0) when no redirect is active.
- Push and pop in the same cycle: count unchanged.
- Overflow cannot occur, because credit counts in-flight requests. No same-cycle pop credit is taken.
- Address arithmetic wraps modulo 2^XLEN. 32'hFFFF_FFFC + 4 → 0.

## Timing
- Values while `reset`=0:
  - `imem_req`=0, `instr_valid`=0, `imem_addr`=`RESET_PC`.
  - `fetch_pc`=`RESET_PC`, `inflight`=0, count=0.
  - `instr_out` and `instr_pc` are 0.
- First cycle after reset release: `imem_req`=1 at `RESET_PC`.
  - First `instr_valid` is 1 cycle later with bypass, 2 cycles later without it.
- Steady state with `instr_ready`=1: one instruction per cycle, no bubbles.
- Redirect asserted in cycle N:
  - Target fetched in cycle N.
  - Target instruction valid in N+1 with bypass, N+2 without.
- Back-pressure: with `instr_ready`=0, requests stop once count + `inflight` = `DEPTH`. They resume the cycle after the first pop.
- Reset asserted mid-operation: all state returns to reset values immediately. Any later `imem_rdata` is ignored.

## Configuration
- `IFQ_BYPASS_EN` defined:
  - When the queue is empty, a response arriving this cycle drives `instr_out`/`instr_pc` combinationally with `instr_valid`=1.
  - If it is popped that cycle, it is not stored.
- Not defined: every response is written to the queue first and becomes visible the next cycle. There is no combinational path from `imem_rdata` to `instr_out`.

## Structure
- Package `ifq_pkg`:
  - `XLEN` default.
  - `RESET_PC` default.
  - Typedef `ifq_entry_t` = {pc, instr}.
- Sub-module `ifq_fifo`:
  - Parameterised circular buffer holding `ifq_entry_t`.
  - Push, pop and synchronous flush.
  - Outputs count and head.
- Top level owns `fetch_pc`, `inflight`, issue logic, redirect and bypass.

## Test plan
- Reset release, `instr_ready`=1, imem returns `addr` as data → PCs 0x4000_0000, 0x4000_0004 … arrive on consecutive cycles, 1 cycle after each request (2 cycles without the macro).
- `instr_ready`=0 from reset → exactly 4 requests issued, then `imem_req`=0. Count=4 with PCs 0x4000_0000–0x4000_000C held. Raise ready → in-order drain, and a new request the cycle after the first pop.
- Queue full, `redirect_valid`=1 with `redirect_pc`=0x4000_0103 → `instr_valid`=0 that cycle, `imem_addr`=0x4000_0100, next valid `instr_pc`=0x4000_0100. No old PCs appear.
- Redirect in the same cycle as a response for 0x4000_0008 → that response is never emitted.
- Assert `reset` mid-stream with 2 entries queued → `instr_valid` drops immediately. After release, fetch restarts at 0x4000_0000.
- `fetch_pc`=0xFFFF_FFFC (via redirect) → next request address is 0x0000_0000.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifq_pkg;

    localparam int unsigned       IFQ_XLEN     = 32;
    localparam logic [IFQ_XLEN-1:0] IFQ_RESET_PC = 32'h4000_0000;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_XLEN-1:0] instr;
    } ifq_entry_t;

    // Sequential successor of a word address; wraps modulo 2^XLEN.
    function automatic logic [IFQ_XLEN-1:0] ifq_next_pc(input logic [IFQ_XLEN-1:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of {pc, instr} entries with push, pop and synchronous flush.
// Flush has priority over push and pop; popping an empty buffer is the caller's job to avoid.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            push_i,
    input  ifq_entry_t      push_data_i,
    input  logic            pop_i,
    output logic [CW-1:0]   count_o,
    output ifq_entry_t      head_o
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    ifq_entry_t       mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_i) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (pop_i) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed through a nonzero count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues 1-cycle-latency imem reads and queues responses for decode.
// Optional build macro IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned          XLEN     = IFQ_XLEN,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = IFQ_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned     CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic [CW-1:0]   fifo_count_s;
    ifq_entry_t      fifo_head_s;
    ifq_entry_t      resp_s;
    logic            push_s;
    logic            pop_s;
    logic [CW:0]     credit_s;
    logic            unused_s;

    assign resp_s   = '{pc: inflight_pc_q, instr: imem_rdata};
    assign unused_s = ^redirect_pc[1:0];

    // Request issue: credit covers queued entries plus the one response still in flight.
    always_comb begin
        credit_s      = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_q};
        imem_req      = 1'b0;
        imem_addr     = RESET_PC;
        if (!reset) begin
            imem_req  = 1'b0;
            imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            imem_req  = 1'b1;
            imem_addr = {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            imem_req  = (credit_s < DEPTH_W);
            imem_addr = fetch_pc_q;
        end
        if (imem_req) begin
            fetch_pc_d    = ifq_next_pc(imem_addr);
            inflight_pc_d = imem_addr;
        end else begin
            fetch_pc_d    = fetch_pc_q;
            inflight_pc_d = inflight_pc_q;
        end
        inflight_d = imem_req;
    end

    // Decode-side view and queue control; a redirect hides and discards everything.
    always_comb begin
        instr_valid = 1'b0;
        instr_out   = {XLEN{1'b0}};
        instr_pc    = {XLEN{1'b0}};
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (!reset || redirect_valid) begin
            instr_valid = 1'b0;
        end else if (fifo_count_s != {CW{1'b0}}) begin
            instr_valid = 1'b1;
            instr_out   = fifo_head_s.instr;
            instr_pc    = fifo_head_s.pc;
            pop_s       = instr_ready;
            push_s      = inflight_q;
`ifdef IFQ_BYPASS_EN
        end else if (inflight_q) begin
            instr_valid = 1'b1;
            instr_out   = resp_s.instr;
            instr_pc    = resp_s.pc;
            push_s      = !instr_ready;
`endif
        end else begin
            push_s      = inflight_q;
        end
    end

    // Fetch PC and in-flight tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push_s),
        .push_data_i (resp_s),
        .pop_i       (pop_s),
        .count_o     (fifo_count_s),
        .head_o      (fifo_head_s)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a queue-level model checked every cycle plus literal spot checks.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h4000_0000;
`ifdef IFQ_BYPASS_EN
    localparam bit          BYP      = 1'b1;
`else
    localparam bit          BYP      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    int vectors = 0;
    int errors  = 0;
    int req_cnt = 0;

    logic        cap_req  = 1'b0;
    logic [31:0] cap_addr = 32'h0;

    logic [31:0] m_q_pc[$];
    logic [31:0] m_q_in[$];
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = 32'h0;
    logic [31:0] m_fpc = 32'h4000_0000;

    instr_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0F0F_F0F0;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Instruction memory with a fixed one-cycle read latency; junk when not requested.
    always @(negedge clk) begin
        cap_req  <= imem_req;
        cap_addr <= imem_addr;
    end
    always @(posedge clk) begin
        imem_rdata <= cap_req ? mem_word(cap_addr) : 32'hDEAD_BEEF;
    end

    // Queue-level model: predict this cycle's outputs, compare, then advance to next cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_req",   {31'd0, imem_req},    32'd0);
                chk("rst_valid", {31'd0, instr_valid}, 32'd0);
                chk("rst_addr",  imem_addr, RESET_PC);
                chk("rst_out",   instr_out, 32'd0);
                chk("rst_pc",    instr_pc,  32'd0);
                m_q_pc.delete();
                m_q_in.delete();
                m_infl = 1'b0;
                m_fpc  = RESET_PC;
            end else begin
                int          sz;
                bit          byp, e_valid, e_req, pop;
                logic [31:0] e_pc, e_in, e_addr;
                sz      = m_q_pc.size();
                byp     = BYP && sz == 0 && m_infl && !redirect_valid;
                e_valid = !redirect_valid && (sz != 0 || byp);
                e_pc    = (sz != 0) ? m_q_pc[0] : m_infl_pc;
                e_in    = (sz != 0) ? m_q_in[0] : mem_word(m_infl_pc);
                e_req   = redirect_valid || (sz + int'(m_infl) < DEPTH);
                e_addr  = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : m_fpc;
                chk("req",   {31'd0, imem_req},    {31'd0, e_req});
                chk("addr",  imem_addr, e_addr);
                chk("valid", {31'd0, instr_valid}, {31'd0, e_valid});
                if (e_valid) begin
                    chk("pc",    instr_pc,  e_pc);
                    chk("instr", instr_out, e_in);
                end
                if (e_req) req_cnt++;
                pop = e_valid && instr_ready;
                if (redirect_valid) begin
                    m_q_pc.delete();
                    m_q_in.delete();
                end else if (pop && sz == 0) begin
                    // bypassed response consumed directly
                end else begin
                    if (pop) begin
                        void'(m_q_pc.pop_front());
                        void'(m_q_in.pop_front());
                    end
                    if (m_infl) begin
                        m_q_pc.push_back(m_infl_pc);
                        m_q_in.push_back(mem_word(m_infl_pc));
                    end
                end
                m_infl = e_req;
                if (e_req) begin
                    m_infl_pc = e_addr;
                    m_fpc     = e_addr + 32'd4;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0;
        bit          found;
        logic [31:0] pattern;

        // Held in reset.
        cyc(3);
        @(negedge clk);
        chk("hold_req",  {31'd0, imem_req}, 32'd0);
        chk("hold_addr", imem_addr, 32'h4000_0000);

        // Release with decode stalled: exactly DEPTH requests, then the queue holds 0..C.
        cyc(1);
        reset = 1'b1;
        r0 = req_cnt;
        @(negedge clk);
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h4000_0000);
        cyc(6);
        chk("req_count", req_cnt - r0, 32'd4);
        chk("model_full", m_q_pc.size(), 32'd4);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("full_noreq", {31'd0, imem_req}, 32'd0);
        chk("full_head",  instr_pc, 32'h4000_0000);
        cyc(1);
        @(negedge clk);
        chk("resume_req",  {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h4000_0010);
        chk("drain_pc",    instr_pc, 32'h4000_0004);
        cyc(10);

        // Fill, then redirect to a misaligned target.
        instr_ready = 1'b0;
        cyc(8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0103;
        @(negedge clk);
        chk("redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_addr",  imem_addr, 32'h4000_0100);
        cyc(1);
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                found = 1'b1;
                chk("redir_first_pc", instr_pc, 32'h4000_0100);
                break;
            end
            cyc(1);
        end
        if (!found) chk("redir_timeout", 32'd0, 32'd1);
        cyc(1);

        // Redirect coinciding with the response for 0x4000_0008.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0000;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0200;
        @(negedge clk);
        chk("stale_resp_here", {31'd0, m_infl}, 32'd1);
        cyc(1);
        redirect_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_stale_pc8", {31'd0, (instr_valid && instr_pc == 32'h4000_0008)}, 32'd0);
            cyc(1);
        end

        // Reset mid-stream with two entries queued.
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0300;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        cyc(1);
        chk("pre_rst_count", m_q_pc.size(), 32'd2);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        cyc(2);
        reset = 1'b1;
        @(negedge clk);
        chk("restart_addr", imem_addr, 32'h4000_0000);
        cyc(1);
        instr_ready = 1'b1;
        cyc(6);

        // Address wrap at the top of the space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
        cyc(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        cyc(6);

        // Irregular decode back-pressure with a redirect in the middle.
        pattern = 32'b1011_0010_1110_0001_1001_1100_0111_0101;
        for (int k = 0; k < 32; k++) begin
            instr_ready    = pattern[k];
            redirect_valid = (k == 17);
            redirect_pc    = 32'h4000_0800;
            cyc(1);
        end
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        cyc(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
